// File: rtl/mux_sched_pkg.sv
// Shared types and constants for the round-robin mux-select scheduler.
package mux_sched_pkg;

  localparam int N_REQ = 8;
  localparam int SEL_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_e;

endpackage

// File: rtl/mux_rr_scheduler_rr_pick8.sv
// Rotating-priority finder: first set bit of ereq scanning from ptr upward, wrapping at 8.
module rr_pick8
  import mux_sched_pkg::*;
(
  input  logic [N_REQ-1:0] ereq_i,
  input  logic [SEL_W-1:0] ptr_i,
  output logic [SEL_W-1:0] winner_o,
  output logic             any_o
);

  logic [SEL_W-1:0] idx;

  // Walk offsets high to low so the smallest offset from ptr is the last to win.
  always_comb begin
    winner_o = '0;
    any_o    = 1'b0;
    idx      = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      idx = ptr_i + SEL_W'(i);
      if (ereq_i[idx]) begin
        winner_o = idx;
        any_o    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_rr_scheduler.sv
// Round-robin owner of the 8:1 result mux: registered one-hot grant and select,
// hold timeout, and a one-cycle dead gap between owners.
module mux_rr_scheduler #(
  parameter int N_REQ    = 8,
  parameter int MAX_HOLD = 16,
  parameter int HOLD_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req_i,
  input  logic [N_REQ-1:0] req_mask_i,
  input  logic             done_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [2:0]       sel_o,
  output logic             sel_valid_o,
  output logic             timeout_o,
  output logic             busy_o
);
  import mux_sched_pkg::state_e;
  import mux_sched_pkg::IDLE;
  import mux_sched_pkg::GRANT;
  import mux_sched_pkg::GAP;

  state_e            state_q;
  logic [N_REQ-1:0]  gnt_q;
  logic [2:0]        sel_q;
  logic              sel_valid_q;
  logic              timeout_q;
  logic              busy_q;
  logic [2:0]        ptr_q;
  logic [HOLD_W-1:0] hold_q;
  logic [HOLD_W-1:0] hold_d;

  logic [N_REQ-1:0]  ereq;
  logic [2:0]        pick_w;
  logic              pick_any;

  assign ereq   = req_i & req_mask_i;
  assign hold_d = hold_q + HOLD_W'(1);

  rr_pick8 u_pick (
    .ereq_i   (ereq),
    .ptr_i    (ptr_q),
    .winner_o (pick_w),
    .any_o    (pick_any)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      sel_q       <= '0;
      sel_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
      busy_q      <= 1'b0;
      ptr_q       <= '0;
      hold_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          timeout_q <= 1'b0;
          if (pick_any) begin
            state_q     <= GRANT;
            gnt_q       <= N_REQ'(1) << pick_w;
            sel_q       <= pick_w;
            sel_valid_q <= 1'b1;
            busy_q      <= 1'b1;
            hold_q      <= HOLD_W'(1);
          end else begin
            busy_q <= 1'b0;
          end
        end
        GRANT: begin
          // done outranks the timeout, so a coincident done never pulses timeout.
          if (done_i || !ereq[sel_q] || hold_q == HOLD_W'(MAX_HOLD)) begin
            state_q     <= GAP;
            gnt_q       <= '0;
            sel_valid_q <= 1'b0;
            ptr_q       <= sel_q + 3'd1;
            timeout_q   <= !done_i && ereq[sel_q];
          end else begin
            hold_q <= hold_d;
          end
        end
        GAP: begin
          state_q   <= IDLE;
          timeout_q <= 1'b0;
          busy_q    <= 1'b0;
        end
        default: begin
          state_q     <= IDLE;
          gnt_q       <= '0;
          sel_valid_q <= 1'b0;
          timeout_q   <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign gnt_o       = gnt_q;
  assign sel_o       = sel_q;
  assign sel_valid_o = sel_valid_q;
  assign timeout_o   = timeout_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_mux_rr_scheduler.sv
// Directed bench for mux_rr_scheduler and its rr_pick8 finder.
module tb_mux_rr_scheduler;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic [7:0] req_mask;
  logic       done;
  logic [7:0] gnt;
  logic [2:0] sel;
  logic       sel_valid;
  logic       timeout;
  logic       busy;

  logic [7:0] p_ereq;
  logic [2:0] p_ptr;
  logic [2:0] p_win;
  logic       p_any;

  int total;
  int bad;

  mux_rr_scheduler #(.N_REQ(8), .MAX_HOLD(16), .HOLD_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_i       (req),
    .req_mask_i  (req_mask),
    .done_i      (done),
    .gnt_o       (gnt),
    .sel_o       (sel),
    .sel_valid_o (sel_valid),
    .timeout_o   (timeout),
    .busy_o      (busy)
  );

  rr_pick8 u_pick (
    .ereq_i   (p_ereq),
    .ptr_i    (p_ptr),
    .winner_o (p_win),
    .any_o    (p_any)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs are driven and outputs sampled on the falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; req_mask = 8'hFF; done = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_pick();
    logic [7:0] e [5] = '{8'h81, 8'h81, 8'h10, 8'hFF, 8'h00};
    logic [2:0] p [5] = '{3'd1, 3'd0, 3'd5, 3'd3, 3'd6};
    logic [2:0] w [5] = '{3'd7, 3'd0, 3'd4, 3'd3, 3'd0};
    logic       a [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++) begin
      p_ereq = e[i]; p_ptr = p[i];
      #1;
      total++;
      if (p_win !== w[i] || p_any !== a[i]) begin
        bad++;
        $display("FAIL pick[%0d]: got win=%0d any=%0b want win=%0d any=%0b", i, p_win, p_any, w[i], a[i]);
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (gnt !== 8'h00 || sel !== 3'd0 || sel_valid !== 1'b0 || timeout !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: got gnt=%h sel=%0d v=%0b to=%0b busy=%0b want all 0", gnt, sel, sel_valid, timeout, busy);
    end
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    req = 8'h04;
    tick();
    total++;
    if (gnt !== 8'h04 || sel !== 3'd2 || sel_valid !== 1'b1 || busy !== 1'b1) begin
      bad++;
      $display("FAIL rst_pre_grant: got gnt=%h sel=%0d v=%0b busy=%0b want 04/2/1/1", gnt, sel, sel_valid, busy);
    end
    rst = 1'b1;
    #1;
    total++;
    if (gnt !== 8'h00 || sel !== 3'd0 || sel_valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL rst_async: got gnt=%h sel=%0d v=%0b busy=%0b want 00/0/0/0", gnt, sel, sel_valid, busy);
    end
    tick();
    rst = 1'b0;
    tick();
    total++;
    if (gnt !== 8'h04 || sel !== 3'd2 || sel_valid !== 1'b1) begin
      bad++;
      $display("FAIL rst_regrant: got gnt=%h sel=%0d v=%0b want 04/2/1", gnt, sel, sel_valid);
    end
  endtask

  task automatic test_round_robin();
    logic [7:0] oh;
    logic [2:0] s;
    do_reset();
    req = 8'hFF;
    for (int i = 0; i < 9; i++) begin
      s  = 3'(i % 8);
      oh = 8'h01 << s;
      tick();
      total++;
      if (gnt !== oh || sel !== s || sel_valid !== 1'b1 || busy !== 1'b1) begin
        bad++;
        $display("FAIL rr_grant[%0d]: got gnt=%h sel=%0d v=%0b want gnt=%h sel=%0d v=1", i, gnt, sel, sel_valid, oh, s);
      end
      done = 1'b1;
      tick();
      done = 1'b0;
      total++;
      if (gnt !== 8'h00 || sel !== s || sel_valid !== 1'b0 || timeout !== 1'b0 || busy !== 1'b1) begin
        bad++;
        $display("FAIL rr_gap[%0d]: got gnt=%h sel=%0d v=%0b to=%0b busy=%0b want 00/%0d/0/0/1", i, gnt, sel, sel_valid, timeout, busy, s);
      end
      tick();
      total++;
      if (gnt !== 8'h00 || busy !== 1'b0 || sel !== s) begin
        bad++;
        $display("FAIL rr_idle[%0d]: got gnt=%h busy=%0b sel=%0d want 00/0/%0d", i, gnt, busy, sel, s);
      end
    end
    req = 8'h00;
  endtask

  task automatic test_mask_wrap();
    do_reset();
    req = 8'h20;
    tick();
    done = 1'b1;
    tick();
    done = 1'b0; req = 8'h81; req_mask = 8'h7F;
    tick();
    tick();
    total++;
    if (gnt !== 8'h01 || sel !== 3'd0) begin
      bad++;
      $display("FAIL mask_wrap: got gnt=%h sel=%0d want 01/0", gnt, sel);
    end
    done = 1'b1;
    tick();
    done = 1'b0; req_mask = 8'hFF;
    tick();
    tick();
    total++;
    if (gnt !== 8'h80 || sel !== 3'd7) begin
      bad++;
      $display("FAIL ptr_after_wrap: got gnt=%h sel=%0d want 80/7", gnt, sel);
    end
  endtask

  task automatic test_timeout();
    int hi;
    do_reset();
    req = 8'h10;
    hi = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (gnt === 8'h10 && timeout === 1'b0) hi++;
    end
    total++;
    if (hi !== 16) begin
      bad++;
      $display("FAIL timeout_hold: got %0d held cycles want 16", hi);
    end
    tick();
    total++;
    if (gnt !== 8'h00 || timeout !== 1'b1 || sel !== 3'd4 || sel_valid !== 1'b0) begin
      bad++;
      $display("FAIL timeout_pulse: got gnt=%h to=%0b sel=%0d v=%0b want 00/1/4/0", gnt, timeout, sel, sel_valid);
    end
    tick();
    total++;
    if (timeout !== 1'b0 || gnt !== 8'h00) begin
      bad++;
      $display("FAIL timeout_width: got to=%0b gnt=%h want 0/00", timeout, gnt);
    end
    tick();
    total++;
    if (gnt !== 8'h10 || sel !== 3'd4) begin
      bad++;
      $display("FAIL timeout_regrant: got gnt=%h sel=%0d want 10/4", gnt, sel);
    end
  endtask

  task automatic test_done_at_timeout();
    do_reset();
    req = 8'h10;
    for (int i = 0; i < 16; i++) tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    total++;
    if (gnt !== 8'h00 || timeout !== 1'b0) begin
      bad++;
      $display("FAIL done_vs_timeout: got gnt=%h to=%0b want 00/0", gnt, timeout);
    end
  endtask

  task automatic test_req_drop();
    do_reset();
    req = 8'h08;
    tick();
    tick();
    req = 8'h00;
    tick();
    total++;
    if (gnt !== 8'h00 || sel !== 3'd3 || sel_valid !== 1'b0 || timeout !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL req_drop: got gnt=%h sel=%0d v=%0b to=%0b busy=%0b want 00/3/0/0/1", gnt, sel, sel_valid, timeout, busy);
    end
    do_reset();
    req = 8'h08;
    tick();
    req_mask = 8'hF7;
    tick();
    total++;
    if (gnt !== 8'h00 || timeout !== 1'b0) begin
      bad++;
      $display("FAIL mask_drop: got gnt=%h to=%0b want 00/0", gnt, timeout);
    end
  endtask

  initial begin
    total = 0; bad = 0;
    rst = 1'b1; req = '0; req_mask = 8'hFF; done = 1'b0;
    p_ereq = '0; p_ptr = '0;
    test_pick();
    test_reset();
    test_reset_mid_grant();
    test_round_robin();
    test_mask_wrap();
    test_timeout();
    test_done_at_timeout();
    test_req_drop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mux_rr_scheduler.md
Name: mux_rr_scheduler

Overview:
Round-robin scheduler that shares the 8-to-1 result multiplexer among up to eight requesting calculator units.
- Arbitrates the req lines and drives the 3-bit mux select (S[2:0] of the 8:1 mux, so S[2] steers the dual 4:1 halves).
- Holds each grant until the owner signals done, drops its request, or times out.
- Inserts one dead cycle between owners so the downstream consumer never sees a glitching select.

Parameters:
N_REQ, 8, number of requesters; fixed at 8 to match the 3-bit select (other values unsupported).
MAX_HOLD, 16, maximum cycles a grant is held before forced release; legal range 1..255.
HOLD_W, 8, width of the hold counter; must satisfy 2^HOLD_W > MAX_HOLD.

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
req  input  8  per-requester request, level-sensitive
req_mask  input  8  1 = requester enabled; masked requests are ignored
done  input  1  owner finished; sampled only in GRANT
gnt  output  8  one-hot grant, registered
sel  output  3  mux select = index of current/last owner, registered
sel_valid  output  1  1 while sel addresses a valid owner, registered
timeout  output  1  one-cycle pulse on forced release
busy  output  1  1 in GRANT or GAP

Behaviour:
- Reset (async, active-high): state=IDLE, gnt=0, sel=0, sel_valid=0, timeout=0, busy=0, ptr=0, hold_cnt=0. Takes effect immediately, mid-grant included. No grant is issued in the cycle reset deasserts unless req is already valid at that edge.
- Effective request: ereq = req & req_mask.
- States:
  - IDLE: if ereq!=0, choose the winner, go to GRANT.
  - GRANT: hold the grant until one of the release conditions below, then go to GAP.
  - GAP: exactly one cycle, then go to IDLE.
- Winner selection: first set bit of ereq scanning ptr, ptr+1, ..., ptr+7, wrapping modulo 8.
- Entering GRANT, the outputs on the next edge are: gnt=onehot(w), sel=w, sel_valid=1, busy=1, hold_cnt=1. This gives 1 cycle latency from req sampled to gnt high.
- In GRANT, each cycle, evaluated in this priority:
  1. done=1 → release, timeout stays 0.
  2. ereq[w]=0 (request dropped or masked) → release, timeout stays 0.
  3. hold_cnt==MAX_HOLD → release, timeout=1 for one cycle (the GAP cycle).
  4. Otherwise hold_cnt increments.
- A simultaneous done and timeout is a normal release with no timeout pulse.
- Release: gnt=0, sel_valid=0, sel holds its value (no select change during GAP), ptr=(w+1) mod 8.
- IDLE: busy=0, sel holds the last value.
- Minimum spacing between grants is 2 cycles (GAP then IDLE arbitration). Back-to-back owners: gnt to A falls at edge k, gnt to B rises at edge k+2.
- Fairness: a continuously requesting, unmasked requester is granted within 7 other grants.
- Only requesters whose ereq bit is set can be granted. A single requester that is continuously valid is re-granted every 3 cycles at minimum; there is no starvation.
- req_mask changes take effect in the same cycle they are sampled.
- Invariants: gnt is zero or one-hot; gnt!=0 ⇔ sel_valid=1; when sel_valid=1, gnt[sel]=1.
- No combinational path from inputs to outputs.

Decomposition:
- Shared package mux_sched_pkg:
  - state enum IDLE/GRANT/GAP (2-bit encoding);
  - constants N_REQ=8 and SEL_W=3.
- One sub-module, rr_pick8: a combinational rotate-priority finder.
  - Inputs: ereq[7:0] and ptr[2:0].
  - Outputs: winner[2:0] and any.
  - Unit-tested on its own.
- The FSM, hold counter, pointer and output registers live in mux_rr_scheduler.

Test Plan:
- Reset mid-grant: req=8'h04, grant issued (sel=2), assert rst for one cycle → gnt=0, sel=0, sel_valid=0 immediately, without waiting for a clock edge; then req=8'h04 held → gnt=8'h04 one cycle after rst falls.
- Round-robin: req=8'hFF, mask=8'hFF, done pulsed one cycle after each grant → sel sequence 0,1,2,...,7,0; each grant starts 2 cycles after the previous release.
- Mask and pointer wrap: ptr=6 after granting 5, req=8'h81, mask=8'h7F → grant sel=0 (bit 7 masked), then ptr=1.
- Timeout: MAX_HOLD=16, req=8'h10 held, done=0 → gnt=8'h10 for exactly 16 cycles, timeout pulse of 1 cycle coincident with gnt=0, then re-grant sel=4 two cycles later.
- Done coincident with timeout at hold_cnt=16 → release, timeout stays 0.
- Request drop: owner 3 deasserts req mid-grant → gnt=0 next edge, sel stays 3 during GAP, sel_valid=0, no timeout.
